// File: rtl/dbl_pkg.sv
// Shared binary64 field constants and converter FSM states for the
// sample <-> double converter family.
package dbl_pkg;

    localparam int DBL_BIAS  = 1023;
    localparam int DBL_EXP_W = 11;
    localparam int DBL_MAN_W = 52;

    localparam logic [63:0] DBL_POS_ZERO = 64'h0000_0000_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        NORM,
        PACK,
        OUT
    } conv_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i (mod N),
// gated by gnt_en_i. Produces a one-hot grant and the granted index.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          gnt_en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_valid_o
);

    always_comb begin
        logic [IW-1:0] idx;
        // NOTE: every variable gets a default before the search loop so no
        // path leaves it unassigned, which would otherwise infer a latch.
        idx         = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr_i) + i) % N);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
            end
        end
        gnt_valid_o = gnt_valid_o & gnt_en_i;
        gnt_o       = gnt_valid_o ? (N'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/sig_to_double_mc.sv
// Multi-channel signed fixed-point to IEEE-754 binary64 converter: per-channel
// holding registers feed one shared shift-normaliser through a round-robin arbiter.
module sig_to_double_mc
    import dbl_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int FRAC_BITS = 15,
    parameter  int CHANNELS  = 2,
    localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_operation,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [63:0]               out_double,
    output logic [CH_BITS-1:0]        out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam logic [11:0] EXP_INIT = 12'(DBL_BIAS + WIDTH - 1 - FRAC_BITS);

    logic [CHANNELS-1:0]  full_q;
    logic [WIDTH-1:0]     hold_q [CHANNELS];

    conv_state_e          state_q;
    logic [CH_BITS-1:0]   ptr_q, ptr_d;
    logic [CH_BITS-1:0]   ch_q;
    logic [WIDTH-1:0]     sample_q;
    logic                 sign_q;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic [11:0]          exp_q;
    logic [63:0]          out_double_q;
    logic [CH_BITS-1:0]   out_ch_q;
    logic                 out_valid_q;

    logic [CHANNELS-1:0]  gnt;
    logic [CH_BITS-1:0]   gnt_idx;
    logic                 gnt_valid;
    logic [DBL_MAN_W-1:0] man_d;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .req_i       (full_q),
        .ptr_i       (ptr_q),
        .gnt_en_i    (state_q == IDLE),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign in_ready = ~full_q & {CHANNELS{~rst}};

    always_ff @(posedge clk_operation) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (rst || gnt[k]) begin
                full_q[k] <= 1'b0;
            end else if (in_valid[k] && in_ready[k]) begin
                // NOTE: sample storage is not reset; the full flag alone says
                // whether its contents mean anything.
                full_q[k] <= 1'b1;
                hold_q[k] <= in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = (gnt_idx == CH_BITS'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        mag_d = sample_q[WIDTH-1] ? (~sample_q + 1'b1) : sample_q;
        man_d = DBL_MAN_W'(mag_q[WIDTH-2:0]) << (DBL_MAN_W + 1 - WIDTH);
    end

    // Normalisation looks one step ahead (LOAD skips NORM when already
    // normalised, NORM exits on the shift that sets the MSB) so a result
    // appears 4+shifts cycles after the sample is accepted.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state_q      <= IDLE;
            ptr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_double_q <= DBL_POS_ZERO;
            out_ch_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        sample_q <= hold_q[gnt_idx];
                        ch_q     <= gnt_idx;
                        ptr_q    <= ptr_d;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    sign_q <= sample_q[WIDTH-1];
                    mag_q  <= mag_d;
                    exp_q  <= EXP_INIT;
                    if (mag_d == '0) begin
                        out_double_q <= DBL_POS_ZERO;
                        out_ch_q     <= ch_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= OUT;
                    end else if (mag_d[WIDTH-1]) begin
                        state_q <= PACK;
                    end else begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (mag_q[WIDTH-1]) begin
                        state_q <= PACK;
                    end else begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 12'd1;
                        if (mag_q[WIDTH-2]) begin
                            state_q <= PACK;
                        end
                    end
                end
                PACK: begin
                    out_double_q <= {sign_q, exp_q[DBL_EXP_W-1:0], man_d};
                    out_ch_q     <= ch_q;
                    out_valid_q  <= 1'b1;
                    state_q      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_double = out_double_q;
    assign out_ch     = out_ch_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != IDLE);

endmodule
